// File: rtl/i_cache_2way_if.sv
// Fetch-side and refill-side bus of the 2-way instruction cache.
// The cache uses the slave modport; the CPU/memory environment uses master.
interface i_cache_2way_if #(
  parameter int A_WIDTH = 32
);
  logic [A_WIDTH-1:0] p_a;
  logic               p_strobe;
  logic [31:0]        p_din;
  logic               p_ready;
  logic               cache_miss;
  logic               p_flush;
  logic [A_WIDTH-1:0] m_a;
  logic               m_strobe;
  logic [31:0]        m_dout;
  logic               m_ready;
  logic [31:0]        perf_hit;
  logic [31:0]        perf_miss;

  modport slave (
    input  p_a, p_strobe, p_flush, m_dout, m_ready,
    output p_din, p_ready, cache_miss, m_a, m_strobe, perf_hit, perf_miss
  );

  modport master (
    output p_a, p_strobe, p_flush, m_dout, m_ready,
    input  p_din, p_ready, cache_miss, m_a, m_strobe, perf_hit, perf_miss
  );
endinterface

// File: rtl/i_cache_2way.sv
// 2-way set-associative instruction cache with multi-word lines.
// Hits answer combinationally; a miss refills the whole line word by word
// and the request then completes as a hit on the first IDLE cycle after.
// Optional feature macro: ICACHE_PERF_CNT_EN (hit/miss performance counters).
//
// state  | meaning
// IDLE   | lookup; hits answered, a strobed miss starts a refill
// REFILL | fetching words 0..WORDS-1 of the victim line from m_*
module i_cache_2way #(
  parameter int A_WIDTH  = 32,
  parameter int C_INDEX  = 6,
  parameter int C_OFFSET = 2
) (
  input logic            clk,
  input logic            clrn,
  i_cache_2way_if.slave  bus
);
  localparam int T_WIDTH = A_WIDTH - C_INDEX - C_OFFSET - 2;
  localparam int WORDS   = 1 << C_OFFSET;
  localparam int SETS    = 1 << C_INDEX;
  // word counter keeps one bit even for one-word lines; it then stays 0
  localparam int OW      = (C_OFFSET > 0) ? C_OFFSET : 1;
  localparam int DW      = C_INDEX + C_OFFSET;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, next_state;

  logic [T_WIDTH-1:0] tag_mem  [2][SETS];
  logic [31:0]        data_mem [2][SETS*WORDS];
  logic [SETS-1:0]    vld [2];
  logic [SETS-1:0]    lru;

  logic [OW-1:0]      word_cnt;
  logic [T_WIDTH-1:0] ltag;
  logic [C_INDEX-1:0] lidx;
  logic               victim;

  logic [T_WIDTH-1:0] p_tag;
  logic [C_INDEX-1:0] p_idx;
  logic [OW-1:0]      p_word;
  logic [DW-1:0]      rd_addr;
  logic [DW-1:0]      wr_addr;
  logic               hit0, hit1, hit;
  logic               victim_sel;
  logic               last_word;

  logic               miss_start, hit_upd, beat, fill_done;

  assign p_tag   = bus.p_a[A_WIDTH-1 -: T_WIDTH];
  assign p_idx   = bus.p_a[C_OFFSET+2 +: C_INDEX];
  assign p_word  = (C_OFFSET == 0) ? '0 : bus.p_a[2 +: OW];
  assign rd_addr = (DW'(p_idx) << C_OFFSET) | DW'(p_word);
  assign wr_addr = (DW'(lidx) << C_OFFSET) | DW'(word_cnt);

  assign hit0 = vld[0][p_idx] & (tag_mem[0][p_idx] == p_tag);
  assign hit1 = vld[1][p_idx] & (tag_mem[1][p_idx] == p_tag);
  assign hit  = hit0 | hit1;
  assign bus.cache_miss = ~hit;
  assign bus.p_din      = hit1 ? data_mem[1][rd_addr] : data_mem[0][rd_addr];

  // invalid ways are filled first; LRU only decides between two valid ways
  assign victim_sel = ~vld[0][p_idx] ? 1'b0 :
                      ~vld[1][p_idx] ? 1'b1 : lru[p_idx];
  assign last_word  = (word_cnt == OW'(WORDS - 1));

  assign bus.m_a = {ltag, lidx, {(C_OFFSET+2){1'b0}}} | (A_WIDTH'(word_cnt) << 2);

  // state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= next_state;
  end

  // next state and handshake outputs; flush overrides everything
  always_comb begin
    next_state   = state;
    bus.p_ready  = 1'b0;
    bus.m_strobe = 1'b0;
    miss_start   = 1'b0;
    hit_upd      = 1'b0;
    beat         = 1'b0;
    fill_done    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.p_strobe && !bus.p_flush) begin
          if (hit) begin
            bus.p_ready = 1'b1;
            hit_upd     = 1'b1;
          end else begin
            miss_start = 1'b1;
            next_state = REFILL;
          end
        end
      end
      REFILL: begin
        bus.m_strobe = 1'b1;
        if (bus.m_ready && !bus.p_flush) begin
          beat = 1'b1;
          if (last_word) begin
            fill_done  = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    if (bus.p_flush) next_state = IDLE;
  end

  // miss context latch and refill word counter
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      word_cnt <= '0;
      ltag     <= '0;
      lidx     <= '0;
      victim   <= 1'b0;
    end else if (miss_start) begin
      word_cnt <= '0;
      ltag     <= p_tag;
      lidx     <= p_idx;
      victim   <= victim_sel;
    end else if (beat && !last_word) begin
      word_cnt <= word_cnt + OW'(1);
    end else if (fill_done || bus.p_flush) begin
      word_cnt <= '0;
    end
  end

  // valid bits and per-set LRU (LRU names the way to evict next)
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      vld[0] <= '0;
      vld[1] <= '0;
      lru    <= '0;
    end else if (bus.p_flush) begin
      vld[0] <= '0;
      vld[1] <= '0;
    end else if (fill_done) begin
      vld[victim][lidx] <= 1'b1;
      lru[lidx]         <= ~victim;
    end else if (hit_upd) begin
      lru[p_idx] <= ~hit1;
    end
  end

  // tag and data arrays carry no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (beat)      data_mem[victim][wr_addr] <= bus.m_dout;
    if (fill_done) tag_mem[victim][lidx]     <= ltag;
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;

  // performance counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_upd)    hit_cnt  <= hit_cnt + 32'd1;
      if (miss_start) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.perf_hit  = hit_cnt;
  assign bus.perf_miss = miss_cnt;
`else
  assign bus.perf_hit  = 32'h0;
  assign bus.perf_miss = 32'h0;
`endif
endmodule
